// File: rtl/md_unit.sv
// md_unit: multiply/divide unit holding the architectural HI/LO registers.
// Runs mult/multu/div/divu as fixed-latency operations: the result is computed
// at start into pending registers and committed to HI/LO when the busy counter
// runs out. mthi/mtlo write HI/LO directly at the end of the EX cycle.
// Optional feature macro: MD_MADD_EN adds madd/maddu/msub/msubu (opcode 0x1C).
//
// state | meaning
// IDLE  | no operation in flight, busy = 0, a start-class op is accepted
// RUN   | operation in flight, busy = 1, counter counts down to 1 then commits
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrEX,
  input  logic [31:0] rsdataEX,
  input  logic [31:0] rtdataEX,
  output logic        start,
  output logic        busy,
  output logic [31:0] hdata,
  output logic [31:0] ldata
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        commit;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_wr_q;

  logic [5:0]  opcode, funct;
  logic        is_special;
  logic        op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
  logic        op_acc, acc_signed, acc_sub;
  logic        start_class, is_div_class, mul_signed;

  logic        unused_bits;
  assign unused_bits = ^instrEX[25:6];

  assign opcode     = instrEX[31:26];
  assign funct      = instrEX[5:0];
  assign is_special = (opcode == 6'h00);
  assign op_mult    = is_special && (funct == F_MULT);
  assign op_multu   = is_special && (funct == F_MULTU);
  assign op_div     = is_special && (funct == F_DIV);
  assign op_divu    = is_special && (funct == F_DIVU);
  assign op_mthi    = is_special && (funct == F_MTHI);
  assign op_mtlo    = is_special && (funct == F_MTLO);

`ifdef MD_MADD_EN
  // madd 0x00, maddu 0x01, msub 0x04, msubu 0x05: funct[0] = unsigned, funct[2] = subtract
  assign op_acc     = (opcode == 6'h1C) && (funct[5:3] == 3'b000) && (funct[1] == 1'b0);
  assign acc_signed = ~funct[0];
  assign acc_sub    = funct[2];
`else
  assign op_acc     = 1'b0;
  assign acc_signed = 1'b0;
  assign acc_sub    = 1'b0;
`endif

  assign is_div_class = op_div | op_divu;
  assign start_class  = op_mult | op_multu | is_div_class | op_acc;
  assign mul_signed   = op_mult | (op_acc & acc_signed);
  assign start        = start_class & ~busy;
  assign busy         = (state_q == RUN);
  assign hdata        = hi_q;
  assign ldata        = lo_q;

  // Product: low 64 bits of the sign- or zero-extended operands is the exact result.
  logic [63:0] prod, acc_base, acc_res;
  always_comb begin
    prod = 64'd0;
    if (mul_signed)
      prod = {{32{rsdataEX[31]}}, rsdataEX} * {{32{rtdataEX[31]}}, rtdataEX};
    else
      prod = {32'd0, rsdataEX} * {32'd0, rtdataEX};
  end

  assign acc_base = {hi_q, lo_q};
  assign acc_res  = acc_sub ? (acc_base - prod) : (acc_base + prod);

  // Divide on magnitudes so that 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  always_comb begin
    a_neg  = op_div & rsdataEX[31];
    b_neg  = op_div & rtdataEX[31];
    a_mag  = a_neg ? (32'd0 - rsdataEX) : rsdataEX;
    b_mag  = b_neg ? (32'd0 - rtdataEX) : rtdataEX;
    b_safe = (rtdataEX == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Result selection for the pending registers; divide by zero suppresses the commit.
  logic [31:0] res_hi, res_lo;
  logic        res_wr;
  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    res_wr = 1'b1;
    if (is_div_class) begin
      res_hi = rem;
      res_lo = quot;
      res_wr = (rtdataEX != 32'd0);
    end else if (op_acc) begin
      res_hi = acc_res[63:32];
      res_lo = acc_res[31:0];
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load the latency on start, count down in RUN, commit at 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_class) begin
          state_d = RUN;
          cnt_d   = is_div_class ? DIV_CYCLES : MULT_CYCLES;
        end
      end
      RUN: begin
        if (cnt_q == 32'd1) begin
          commit  = 1'b1;
          state_d = IDLE;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // Capture the result at start; held until commit or discarded by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else if (start) begin
      pend_hi_q <= res_hi;
      pend_lo_q <= res_lo;
      pend_wr_q <= res_wr;
    end
  end

  // HI/LO: direct moves take effect immediately; a commit on the same edge wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (op_mthi) hi_q <= rsdataEX;
      if (op_mtlo) lo_q <= rsdataEX;
      if (commit && pend_wr_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, rs, rt;
  logic        start, busy;
  logic [31:0] hdata, ldata;

  int n_cmp = 0;
  int n_bad = 0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .instrEX(instr), .rsdataEX(rs), .rtdataEX(rt),
    .start(start), .busy(busy), .hdata(hdata), .ldata(ldata)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_NOP   = 32'h0000_0000;
  localparam logic [31:0] I_MTHI  = 32'h0000_0011;
  localparam logic [31:0] I_MTLO  = 32'h0000_0013;
  localparam logic [31:0] I_MULT  = 32'h0000_0018;
  localparam logic [31:0] I_MULTU = 32'h0000_0019;
  localparam logic [31:0] I_DIV   = 32'h0000_001A;
  localparam logic [31:0] I_DIVU  = 32'h0000_001B;
  localparam logic [31:0] I_MADDU = 32'h7000_0001;

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    instr = i; rs = a; rt = b;
    #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    instr = I_NOP; rs = 32'd0; rt = 32'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(I_NOP, 0, 0);
    step(); step();
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0h want 0", busy); end
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL reset_start got %0h want 0", start); end
    n_cmp++; if (hdata !== 32'd0) begin n_bad++; $display("FAIL reset_hdata got %08h want 0", hdata); end
    n_cmp++; if (ldata !== 32'd0) begin n_bad++; $display("FAIL reset_ldata got %08h want 0", ldata); end
  endtask

  task automatic test_mult();
    int n;
    drive(I_MULT, 32'hFFFF_FFFE, 32'd3);
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL mult_start got %0h want 1", start); end
    step();
    wait_idle(n);
    n_cmp++; if (n != MC) begin n_bad++; $display("FAIL mult_busy_cycles got %0d want %0d", n, MC); end
    n_cmp++; if (hdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi got %08h want ffffffff", hdata); end
    n_cmp++; if (ldata !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL mult_lo got %08h want fffffffa", ldata); end
    drive(I_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    wait_idle(n);
    n_cmp++; if (n != MC) begin n_bad++; $display("FAIL multu_busy_cycles got %0d want %0d", n, MC); end
    n_cmp++; if (hdata !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi got %08h want fffffffe", hdata); end
    n_cmp++; if (ldata !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo got %08h want 00000001", ldata); end
  endtask

  task automatic test_div();
    int n;
    drive(I_DIV, 32'hFFFF_FFF9, 32'd2);
    step();
    wait_idle(n);
    n_cmp++; if (n != DC) begin n_bad++; $display("FAIL div_busy_cycles got %0d want %0d", n, DC); end
    n_cmp++; if (ldata !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo got %08h want fffffffd", ldata); end
    n_cmp++; if (hdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi got %08h want ffffffff", hdata); end
    drive(I_DIVU, 32'd7, 32'd0);
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL divz_start got %0h want 1", start); end
    step();
    wait_idle(n);
    n_cmp++; if (n != DC) begin n_bad++; $display("FAIL divz_busy_cycles got %0d want %0d", n, DC); end
    n_cmp++; if (ldata !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL divz_lo got %08h want fffffffd", ldata); end
    n_cmp++; if (hdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divz_hi got %08h want ffffffff", hdata); end
    drive(I_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    step();
    wait_idle(n);
    n_cmp++; if (ldata !== 32'h8000_0000) begin n_bad++; $display("FAIL divovf_lo got %08h want 80000000", ldata); end
    n_cmp++; if (hdata !== 32'h0000_0000) begin n_bad++; $display("FAIL divovf_hi got %08h want 0", hdata); end
  endtask

  task automatic test_mthi_mtlo();
    drive(I_MTHI, 32'h0000_1234, 32'd0);
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL mthi_start got %0h want 0", start); end
    step();
    n_cmp++; if (hdata !== 32'h0000_1234) begin n_bad++; $display("FAIL mthi_hi got %08h want 00001234", hdata); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy got %0h want 0", busy); end
    drive(I_MTLO, 32'h0000_5678, 32'd0);
    step();
    n_cmp++; if (ldata !== 32'h0000_5678) begin n_bad++; $display("FAIL mtlo_lo got %08h want 00005678", ldata); end
    n_cmp++; if (hdata !== 32'h0000_1234) begin n_bad++; $display("FAIL mtlo_hi_kept got %08h want 00001234", hdata); end
  endtask

  task automatic test_back_to_back();
    int n;
    drive(I_MULTU, 32'd3, 32'd4);
    step();
    wait_idle(n);
    n_cmp++; if (ldata !== 32'd12) begin n_bad++; $display("FAIL b2b_first_lo got %08h want 0000000c", ldata); end
    drive(I_MULTU, 32'd5, 32'd6);
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL b2b_start got %0h want 1", start); end
    step();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got %0h want 1", busy); end
    drive(I_MTHI, 32'h0000_AAAA, 32'd0);
    step();
    n_cmp++; if (hdata !== 32'h0000_AAAA) begin n_bad++; $display("FAIL busy_mthi got %08h want 0000aaaa", hdata); end
    wait_idle(n);
    n_cmp++; if (n != MC - 1) begin n_bad++; $display("FAIL b2b_busy_cycles got %0d want %0d", n, MC - 1); end
    n_cmp++; if (hdata !== 32'd0) begin n_bad++; $display("FAIL b2b_hi got %08h want 0", hdata); end
    n_cmp++; if (ldata !== 32'd30) begin n_bad++; $display("FAIL b2b_lo got %08h want 0000001e", ldata); end
  endtask

  task automatic test_ignore_while_busy();
    int n;
    drive(I_DIVU, 32'd100, 32'd7);
    step();
    step();
    drive(I_MULT, 32'd3, 32'd3);
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL ign_start got %0h want 0", start); end
    step();
    wait_idle(n);
    n_cmp++; if (n != DC - 2) begin n_bad++; $display("FAIL ign_busy_cycles got %0d want %0d", n, DC - 2); end
    n_cmp++; if (ldata !== 32'd14) begin n_bad++; $display("FAIL ign_lo got %08h want 0000000e", ldata); end
    n_cmp++; if (hdata !== 32'd2) begin n_bad++; $display("FAIL ign_hi got %08h want 00000002", hdata); end
  endtask

  task automatic test_reset_abort();
    int seen_busy;
    drive(I_DIV, 32'd100, 32'd7);
    step();
    step(); step(); step();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before got %0h want 1", busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %0h want 0", busy); end
    n_cmp++; if (hdata !== 32'd0) begin n_bad++; $display("FAIL abort_hi got %08h want 0", hdata); end
    n_cmp++; if (ldata !== 32'd0) begin n_bad++; $display("FAIL abort_lo got %08h want 0", ldata); end
    seen_busy = 0;
    for (int i = 0; i < 15; i++) begin
      if (busy !== 1'b0) seen_busy++;
      step();
    end
    n_cmp++; if (seen_busy != 0) begin n_bad++; $display("FAIL abort_busy_later got %0d want 0", seen_busy); end
    n_cmp++; if (ldata !== 32'd0) begin n_bad++; $display("FAIL abort_no_commit_lo got %08h want 0", ldata); end
    n_cmp++; if (hdata !== 32'd0) begin n_bad++; $display("FAIL abort_no_commit_hi got %08h want 0", hdata); end
  endtask

  task automatic test_madd();
    int n;
    drive(I_MTHI, 32'd0, 32'd0);
    step();
    drive(I_MTLO, 32'hFFFF_FFFF, 32'd0);
    step();
    drive(I_MADDU, 32'd1, 32'd1);
`ifdef MD_MADD_EN
    n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL maddu_start got %0h want 1", start); end
    step();
    wait_idle(n);
    n_cmp++; if (n != MC) begin n_bad++; $display("FAIL maddu_busy_cycles got %0d want %0d", n, MC); end
    n_cmp++; if (hdata !== 32'd1) begin n_bad++; $display("FAIL maddu_hi got %08h want 00000001", hdata); end
    n_cmp++; if (ldata !== 32'd0) begin n_bad++; $display("FAIL maddu_lo got %08h want 0", ldata); end
`else
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL maddu_off_start got %0h want 0", start); end
    step();
    wait_idle(n);
    n_cmp++; if (n != 0) begin n_bad++; $display("FAIL maddu_off_busy got %0d want 0", n); end
    n_cmp++; if (hdata !== 32'd0) begin n_bad++; $display("FAIL maddu_off_hi got %08h want 0", hdata); end
    n_cmp++; if (ldata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL maddu_off_lo got %08h want ffffffff", ldata); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    instr = I_NOP; rs = 32'd0; rt = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_abort();
    test_madd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
